// File: rtl/m_extension_unit.sv
// m_extension_unit: iterative RV32M multiply/divide unit for the EX stage.
// One op per accepted start, one-cycle done pulse with the result.
// Multiply is shift-add retiring MUL_RADIX bits per cycle; divide is restoring,
// one quotient bit per cycle. Signed ops work on magnitudes and fix the sign at the end.
// Optional feature: define M_PAIR_REUSE_EN to keep the last divide's quotient and
// remainder so a matching div/rem pair completes without recomputation.
module m_extension_unit #(
    parameter int XLEN      = 32,
    parameter int MUL_RADIX = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_t;

    localparam int CW      = $clog2(XLEN) + 1;
    localparam int MUL_CYC = XLEN / MUL_RADIX;

    state_t              state_q, state_d;
    m_funct3_t           f3_q, f3_d;
    logic [XLEN-1:0]     opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     opm_q, opm_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [XLEN-1:0]     result_q, result_d;

`ifdef M_PAIR_REUSE_EN
    logic                reuse_valid_q, reuse_valid_d;
    logic                reuse_signed_q, reuse_signed_d;
    logic [XLEN-1:0]     reuse_a_q, reuse_a_d;
    logic [XLEN-1:0]     reuse_b_q, reuse_b_d;
    logic [XLEN-1:0]     reuse_quo_q, reuse_quo_d;
    logic [XLEN-1:0]     reuse_rem_q, reuse_rem_d;
    logic                reuse_hit;
`endif

    // Operand interpretation helpers derived from the latched funct3.
    logic                is_div, div_signed, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                is_int_min, is_minus_one;
    logic [XLEN+MUL_RADIX-1:0] mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    assign is_div       = f3_q[2];
    assign div_signed   = ~f3_q[0];
    assign a_signed     = is_div ? div_signed : (f3_q == F3_MULH || f3_q == F3_MULHSU);
    assign b_signed     = is_div ? div_signed : (f3_q == F3_MULH);
    assign a_neg        = a_signed & opa_q[XLEN-1];
    assign b_neg        = b_signed & opb_q[XLEN-1];
    assign abs_a        = a_neg ? ('0 - opa_q) : opa_q;
    assign abs_b        = b_neg ? ('0 - opb_q) : opb_q;
    assign is_int_min   = (opa_q == {1'b1, {(XLEN-1){1'b0}}});
    assign is_minus_one = (opb_q == '1);

    // One multiply step: add multiplicand times the low digit, then shift right.
    assign mul_sum  = {{MUL_RADIX{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                    + ({{MUL_RADIX{1'b0}}, opm_q} * {{XLEN{1'b0}}, acc_q[MUL_RADIX-1:0]});
    assign mul_next = {mul_sum, acc_q[XLEN-1:MUL_RADIX]};

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opm_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    assign prod_fix = negq_q ? ('0 - acc_q) : acc_q;
    assign quo_fix  = negq_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem_fix  = negr_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

`ifdef M_PAIR_REUSE_EN
    assign reuse_hit = reuse_valid_q && (opa_q == reuse_a_q) && (opb_q == reuse_b_q)
                     && (div_signed == reuse_signed_q);
`endif

    assign busy_o   = (state_q == S_PREP) || (state_q == S_MUL)
                   || (state_q == S_DIV)  || (state_q == S_FIXUP);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

    // Next-state logic: sequencing, datapath steps, result selection and flush override.
    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opm_d    = opm_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
`ifdef M_PAIR_REUSE_EN
        reuse_valid_d  = reuse_valid_q;
        reuse_signed_d = reuse_signed_q;
        reuse_a_d      = reuse_a_q;
        reuse_b_d      = reuse_b_q;
        reuse_quo_d    = reuse_quo_q;
        reuse_rem_d    = reuse_rem_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i && !flush_i) begin
                    f3_d    = m_funct3_t'(funct3_i);
                    opa_d   = rs1_i;
                    opb_d   = rs2_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (is_div) begin
                    if (opb_q == '0) begin
                        result_d = f3_q[1] ? opa_q : '1;
                        state_d  = S_DONE;
                    end else if (div_signed && is_int_min && is_minus_one) begin
                        result_d = f3_q[1] ? '0 : opa_q;
                        state_d  = S_DONE;
`ifdef M_PAIR_REUSE_EN
                    end else if (reuse_hit) begin
                        result_d = f3_q[1] ? reuse_rem_q : reuse_quo_q;
                        state_d  = S_DONE;
`endif
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        opm_d   = abs_b;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = S_DIV;
                    end
                end else begin
                    if (opa_q == '0 || opb_q == '0) begin
                        result_d = '0;
                        state_d  = S_DONE;
`ifdef M_PAIR_REUSE_EN
                        reuse_valid_d = 1'b0;
`endif
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, abs_b};
                        opm_d   = abs_a;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = 1'b0;
                        cnt_d   = CW'(MUL_CYC - 1);
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_DONE;
                if (is_div) begin
                    result_d = f3_q[1] ? rem_fix : quo_fix;
`ifdef M_PAIR_REUSE_EN
                    reuse_valid_d  = 1'b1;
                    reuse_signed_d = div_signed;
                    reuse_a_d      = opa_q;
                    reuse_b_d      = opb_q;
                    reuse_quo_d    = quo_fix;
                    reuse_rem_d    = rem_fix;
`endif
                end else begin
                    result_d = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef M_PAIR_REUSE_EN
                    reuse_valid_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush kills the in-flight op: no done pulse, result untouched.
        if (flush_i && busy_o) begin
            state_d  = S_IDLE;
            result_d = result_q;
`ifdef M_PAIR_REUSE_EN
            reuse_valid_d = 1'b0;
`endif
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            f3_q     <= F3_MUL;
            opa_q    <= '0;
            opb_q    <= '0;
            opm_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opm_q    <= opm_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

`ifdef M_PAIR_REUSE_EN
    // Reuse register holding the last completed divide's operands and results.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reuse_valid_q  <= 1'b0;
            reuse_signed_q <= 1'b0;
            reuse_a_q      <= '0;
            reuse_b_q      <= '0;
            reuse_quo_q    <= '0;
            reuse_rem_q    <= '0;
        end else begin
            reuse_valid_q  <= reuse_valid_d;
            reuse_signed_q <= reuse_signed_d;
            reuse_a_q      <= reuse_a_d;
            reuse_b_q      <= reuse_b_d;
            reuse_quo_q    <= reuse_quo_d;
            reuse_rem_q    <= reuse_rem_d;
        end
    end
`endif

endmodule

// File: tb/tb_m_extension_unit.sv
// Directed testbench for m_extension_unit: hand-computed results and latencies.
module tb_m_extension_unit;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

`ifdef M_PAIR_REUSE_EN
    localparam int REUSE_LAT = 2;
`else
    localparam int REUSE_LAT = 35;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checkCount = 0;
    int errorCount = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    m_extension_unit #(.XLEN(32), .MUL_RADIX(1)) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .start_i  (start),
        .flush_i  (flush),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one op for a single accept edge, then scramble the inputs.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = ~f3;
        rs1    = ~a;
        rs2    = ~b;
    endtask

    // Wait (bounded) for done, then check result, latency and busy in the done cycle.
    task automatic waitResult(input string tag, input logic [31:0] expRes, input int expLat);
        int lat = 0;
        bit seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_result"}, result, expRes);
            checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
            checkOutput({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        bit sawDone;
        bit sawBusy;

        rstN   = 1'b0;
        start  = 1'b1;
        flush  = 1'b0;
        funct3 = DIV;
        rs1    = 32'd100;
        rs2    = 32'd7;

        // Reset held with start asserted: nothing may be accepted.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", {31'b0, busy}, 32'd0);

        // Multiply variants.
        applyStimulus(MUL, 32'd7, 32'hFFFFFFFD);
        waitResult("mul_7_m3", 32'hFFFFFFEB, 35);
        applyStimulus(MULH, 32'd7, 32'hFFFFFFFD);
        waitResult("mulh_7_m3", 32'hFFFFFFFF, 35);
        applyStimulus(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitResult("mulhu_max", 32'hFFFFFFFE, 35);
        applyStimulus(MULHSU, 32'hFFFFFFFE, 32'd3);
        waitResult("mulhsu_m2_3", 32'hFFFFFFFF, 35);
        applyStimulus(MULHSU, 32'd2, 32'hFFFFFFFF);
        waitResult("mulhsu_2_max", 32'h00000001, 35);
        applyStimulus(MUL, 32'd0, 32'd5);
        waitResult("mul_zero", 32'h00000000, 2);

        // Divide variants.
        applyStimulus(DIV, 32'hFFFFFFEC, 32'd3);
        waitResult("div_m20_3", 32'hFFFFFFFA, 35);
        applyStimulus(REM, 32'hFFFFFFEC, 32'd3);
        waitResult("rem_m20_3", 32'hFFFFFFFE, REUSE_LAT);
        applyStimulus(DIVU, 32'hFFFFFFFF, 32'd16);
        waitResult("divu_max_16", 32'h0FFFFFFF, 35);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("async_reset_result", result, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Special cases complete straight from PREP.
        applyStimulus(DIVU, 32'd123, 32'd0);
        waitResult("divu_by_zero", 32'hFFFFFFFF, 2);
        applyStimulus(REM, 32'd5, 32'd0);
        waitResult("rem_by_zero", 32'h00000005, 2);
        applyStimulus(DIV, 32'h80000000, 32'hFFFFFFFF);
        waitResult("div_overflow", 32'h80000000, 2);
        applyStimulus(REM, 32'h80000000, 32'hFFFFFFFF);
        waitResult("rem_overflow", 32'h00000000, 2);

        applyStimulus(REMU, 32'd100, 32'd7);
        waitResult("remu_100_7", 32'h00000002, 35);

        // Flush ten cycles into a divide, with a competing start in the same cycle.
        applyStimulus(DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        applyStimulus(MUL, 32'd3, 32'd4);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        sawDone = 1'b0;
        sawBusy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("flush_no_done", {31'b0, sawDone}, 32'd0);
        checkOutput("flush_start_dropped", {31'b0, sawBusy}, 32'd0);
        checkOutput("flush_result_kept", result, 32'h00000002);
        applyStimulus(DIVU, 32'd1000, 32'd10);
        waitResult("divu_after_flush", 32'd100, 35);

        // Back-to-back: next start issued in the done cycle.
        applyStimulus(DIV, 32'd100, 32'd7);
        waitResult("div_100_7", 32'd14, 35);
        applyStimulus(REM, 32'd100, 32'd7);
        waitResult("rem_100_7_b2b", 32'd2, REUSE_LAT);
        applyStimulus(MUL, 32'd3, 32'd4);
        waitResult("mul_3_4_b2b", 32'd12, 35);
        applyStimulus(DIV, 32'd100, 32'd7);
        waitResult("div_100_7_after_mul", 32'd14, 35);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
